// File: rtl/handler_seq.sv
// Tester-handler sequencer: conditions start-of-test, runs one device test with timeout,
// and drives a one-hot bin bus that is stable for a fixed setup time before EOT rises.
module handler_seq #(
    parameter int NBIN        = 10,
    parameter int DEB_CYC     = 16,
    parameter int SETUP_CYC   = 100,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int TO_BIN      = 9,
    parameter int ERR_BIN     = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SOT_RAW,
    input  logic                    PROG_SOT,
    input  logic                    SEL_MANUAL,
    input  logic                    ABORT,
    input  logic                    TST_DONE,
    input  logic [$clog2(NBIN)-1:0] TST_BIN,
    output logic                    TST_START,
    output logic                    TST_ACTIVE,
    output logic                    EOT,
    output logic [NBIN-1:0]         BIN,
    output logic                    TIMEOUT_FLG,
    output logic [15:0]             TEST_CNT,
    output logic [2:0]              STATE
);
    localparam int BW = $clog2(NBIN);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int SW = $clog2(SETUP_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [DW-1:0]   DEB_LAST   = DW'(DEB_CYC - 1);
    localparam logic [DW-1:0]   DEB_MAX    = DW'(DEB_CYC);
    localparam logic [SW-1:0]   SETUP_LAST = SW'(SETUP_CYC - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [NBIN-1:0] TO_MASK    = NBIN'(1) << TO_BIN;
    localparam logic [NBIN-1:0] ERR_MASK   = NBIN'(1) << ERR_BIN;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TEST     = 3'd1,
        S_SETUP    = 3'd2,
        S_EOT_HOLD = 3'd3
    } state_t;

    logic            sot_sel;
    logic [1:0]      sync_reg;
    logic [DW-1:0]   deb_cnt_reg;
    logic            qual_sot_reg;
    logic [NBIN-1:0] done_hot;
    logic [NBIN-1:0] done_mask;

    state_t          state_reg;
    logic [TW-1:0]   timer_reg;
    logic [SW-1:0]   setup_reg;
    logic            tst_start_reg;
    logic            tst_active_reg;
    logic            eot_reg;
    logic [NBIN-1:0] bin_reg;
    logic            timeout_flg_reg;
    logic [15:0]     test_cnt_reg;

    assign sot_sel = SEL_MANUAL ? PROG_SOT : SOT_RAW;

    // The count saturates at DEB_CYC so the qualifier fires once per high period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_reg     <= '0;
            deb_cnt_reg  <= '0;
            qual_sot_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], sot_sel};
            qual_sot_reg <= sync_reg[1] && (deb_cnt_reg == DEB_LAST);
            if (!sync_reg[1])
                deb_cnt_reg <= '0;
            else if (deb_cnt_reg != DEB_MAX)
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBIN; gi++) begin : g_bin_dec
            assign done_hot[gi] = (TST_BIN == BW'(gi));
        end
    endgenerate

    // An index with no matching output line is reported on the error bin.
    assign done_mask = (|done_hot) ? done_hot : ERR_MASK;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg       <= S_IDLE;
            timer_reg       <= '0;
            setup_reg       <= '0;
            tst_start_reg   <= 1'b0;
            tst_active_reg  <= 1'b0;
            eot_reg         <= 1'b0;
            bin_reg         <= '0;
            timeout_flg_reg <= 1'b0;
            test_cnt_reg    <= '0;
        end else begin
            tst_start_reg <= 1'b0;
            if (ABORT) begin
                state_reg       <= S_IDLE;
                tst_active_reg  <= 1'b0;
                eot_reg         <= 1'b0;
                bin_reg         <= '0;
                timeout_flg_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE, S_EOT_HOLD: begin
                        if (qual_sot_reg) begin
                            tst_start_reg   <= 1'b1;
                            tst_active_reg  <= 1'b1;
                            eot_reg         <= 1'b0;
                            bin_reg         <= '0;
                            timeout_flg_reg <= 1'b0;
                            timer_reg       <= '0;
                            state_reg       <= S_TEST;
                        end
                    end
                    S_TEST: begin
                        if (TST_DONE) begin
                            bin_reg        <= done_mask;
                            tst_active_reg <= 1'b0;
                            setup_reg      <= '0;
                            state_reg      <= S_SETUP;
                        end else if (timer_reg == TIMER_LAST) begin
                            bin_reg         <= TO_MASK;
                            timeout_flg_reg <= 1'b1;
                            tst_active_reg  <= 1'b0;
                            setup_reg       <= '0;
                            state_reg       <= S_SETUP;
                        end else begin
                            timer_reg <= timer_reg + 1'b1;
                        end
                    end
                    S_SETUP: begin
                        if (setup_reg == SETUP_LAST) begin
                            eot_reg   <= 1'b1;
                            state_reg <= S_EOT_HOLD;
                            if (test_cnt_reg != 16'hFFFF)
                                test_cnt_reg <= test_cnt_reg + 1'b1;
                        end else begin
                            setup_reg <= setup_reg + 1'b1;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign TST_START   = tst_start_reg;
    assign TST_ACTIVE  = tst_active_reg;
    assign EOT         = eot_reg;
    assign BIN         = bin_reg;
    assign TIMEOUT_FLG = timeout_flg_reg;
    assign TEST_CNT    = test_cnt_reg;
    assign STATE       = state_reg;
endmodule
